// File: rtl/cnf_group_eval_pkg.sv
// -----------------------------------------------------------------------------
// cnf_pkg
// Shared types and constants for the streaming CNF evaluator.
//   cnf_state_e  : evaluator FSM states (IDLE, EVAL, DONE)
//   cnf_lit_t    : one literal, {neg, idx}; idx is held at a fixed maximum width
//                  so the type does not depend on the NUM_VARS parameter
//   CNF_TRACE_W  : width of the optional unsat trace counters
// -----------------------------------------------------------------------------
package cnf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } cnf_state_e;

  // Widest variable index supported (IDXW must not exceed this).
  localparam int CNF_IDX_W = 16;

  typedef struct packed {
    logic                 neg;
    logic [CNF_IDX_W-1:0] idx;
  } cnf_lit_t;

  localparam int CNF_TRACE_W = 16;

endpackage

// File: rtl/cnf_group_eval_if.sv
// -----------------------------------------------------------------------------
// cnf_group_eval_if
// Bundles the run control, the clause stream and the result handshake of
// cnf_group_eval.
//   master : clause source / result consumer side
//   slave  : evaluator side
// Signals:
//   start, asg                      run start pulse and variable assignment
//   cl_valid/cl_ready, cl_lits,     clause stream; literal k sits at slice k
//   cl_grp_last, cl_last            as {neg, idx}
//   res_valid/res_ready             result handshake
//   res_grp_sat, res_all_sat,       verdicts and group overflow flag
//   res_ovf
//   busy                            high while evaluating
//   res_unsat_cnt, res_first_fail   only with CNF_UNSAT_TRACE_EN defined
// -----------------------------------------------------------------------------
interface cnf_group_eval_if
  import cnf_pkg::*;
#(
  parameter int NUM_VARS = 256,
  parameter int LITS     = 2,
  parameter int GROUPS   = 4,
  parameter int IDXW     = $clog2(NUM_VARS)
);
  localparam int LIT_W = IDXW + 1;

  logic                    start;
  logic [NUM_VARS-1:0]     asg;
  logic                    cl_valid;
  logic                    cl_ready;
  logic [LITS*LIT_W-1:0]   cl_lits;
  logic                    cl_grp_last;
  logic                    cl_last;
  logic                    res_valid;
  logic                    res_ready;
  logic [GROUPS-1:0]       res_grp_sat;
  logic                    res_all_sat;
  logic                    res_ovf;
  logic                    busy;
`ifdef CNF_UNSAT_TRACE_EN
  logic [CNF_TRACE_W-1:0]  res_unsat_cnt;
  logic [CNF_TRACE_W-1:0]  res_first_fail;
`endif

  modport master (
`ifdef CNF_UNSAT_TRACE_EN
    input  res_unsat_cnt, res_first_fail,
`endif
    output start, asg, cl_valid, cl_lits, cl_grp_last, cl_last, res_ready,
    input  cl_ready, res_valid, res_grp_sat, res_all_sat, res_ovf, busy
  );

  modport slave (
`ifdef CNF_UNSAT_TRACE_EN
    output res_unsat_cnt, res_first_fail,
`endif
    input  start, asg, cl_valid, cl_lits, cl_grp_last, cl_last, res_ready,
    output cl_ready, res_valid, res_grp_sat, res_all_sat, res_ovf, busy
  );

endinterface

// File: rtl/cnf_group_eval_clause_or.sv
// -----------------------------------------------------------------------------
// cnf_clause_or
// Combinational value of one clause: OR over LITS literals of asg_q[idx]^neg.
// A literal whose idx is outside 0..NUM_VARS-1 evaluates to 0 regardless of
// its polarity.
// Ports:
//   asg_q   in  NUM_VARS          captured assignment
//   cl_lits in  LITS*(IDXW+1)     literal k = {neg, idx} at slice k
//   clause  out 1                 clause value
// -----------------------------------------------------------------------------
module cnf_clause_or
  import cnf_pkg::*;
#(
  parameter int NUM_VARS = 256,
  parameter int LITS     = 2,
  parameter int IDXW     = $clog2(NUM_VARS)
) (
  input  logic [NUM_VARS-1:0]        asg_q,
  input  logic [LITS*(IDXW+1)-1:0]   cl_lits,
  output logic                       clause
);

  localparam int LIT_W = IDXW + 1;
  // Assignment widened to every index the idx field can encode, so the
  // variable select never runs past the vector; out-of-range slots read 0
  // and are masked off again by the range check below.
  localparam int EXT_W = 1 << IDXW;

  logic [EXT_W-1:0] asg_ext;
  logic [LITS-1:0]  lit_val;

  assign asg_ext = EXT_W'(asg_q);

  for (genvar k = 0; k < LITS; k++) begin : g_lit
    cnf_lit_t lit;
    logic     in_range;

    assign lit      = {cl_lits[k*LIT_W + IDXW], CNF_IDX_W'(cl_lits[k*LIT_W +: IDXW])};
    assign in_range = (lit.idx < CNF_IDX_W'(NUM_VARS));
    assign lit_val[k] = in_range & (asg_ext[lit.idx[IDXW-1:0]] ^ lit.neg);
  end

  assign clause = |lit_val;

endmodule

// File: rtl/cnf_group_eval.sv
// -----------------------------------------------------------------------------
// cnf_group_eval
// Streaming CNF evaluator. start captures the assignment, then one clause per
// cycle is accepted while in EVAL. Clauses are ANDed per group (closed by
// cl_grp_last or cl_last) and over the whole run. The result is held in DONE
// until res_ready, or dropped by a new start.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  cnf_group_eval_if.slave (see interface header)
// Optional feature: define CNF_UNSAT_TRACE_EN to add res_unsat_cnt
// (saturating failing-clause count) and res_first_fail (beat index of the
// first failing clause, 16'hFFFF if none).
// -----------------------------------------------------------------------------
module cnf_group_eval
  import cnf_pkg::*;
#(
  parameter int NUM_VARS = 256,
  parameter int LITS     = 2,
  parameter int GROUPS   = 4,
  parameter int IDXW     = $clog2(NUM_VARS)
) (
  input  logic             clk,
  input  logic             rst,
  cnf_group_eval_if.slave  bus
);

  // Group pointer must be able to hold GROUPS itself (the "full" value).
  localparam int GRP_W = $clog2(GROUPS + 1);

  cnf_state_e          state_q, state_d;
  logic [NUM_VARS-1:0] asg_q;
  logic                acc_q;
  logic [GRP_W-1:0]    grp_q;
  logic [GROUPS-1:0]   grp_sat_q;
  logic                all_sat_q;
  logic                ovf_q;

  logic clause;
  logic start_ok;
  logic beat;
  logic close;

  assign start_ok = bus.start & ((state_q == IDLE) | (state_q == DONE));
  assign beat     = bus.cl_valid & (state_q == EVAL);
  assign close    = beat & (bus.cl_grp_last | bus.cl_last);

  cnf_clause_or #(
    .NUM_VARS (NUM_VARS),
    .LITS     (LITS),
    .IDXW     (IDXW)
  ) u_clause_or (
    .asg_q   (asg_q),
    .cl_lits (bus.cl_lits),
    .clause  (clause)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff reads the pre-edge value of every other register.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: next state defaults to the current state before the case, so no
    // path through the block leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = EVAL;
      EVAL: if (beat && bus.cl_last) state_d = DONE;
      // A new start beats res_ready: the pending result is simply dropped.
      DONE: begin
        if (start_ok)           state_d = EVAL;
        else if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cl_ready  = (state_q == EVAL);
  assign bus.busy      = (state_q == EVAL);
  assign bus.res_valid = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Assignment, accumulators and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the assignment register is reset along with the control state so
    // a reset mid-run leaves nothing of the discarded run visible.
    if (rst) begin
      asg_q     <= '0;
      acc_q     <= 1'b1;
      grp_q     <= '0;
      grp_sat_q <= '1;
      all_sat_q <= 1'b1;
      ovf_q     <= 1'b0;
    end else if (start_ok) begin
      asg_q     <= bus.asg;
      acc_q     <= 1'b1;
      grp_q     <= '0;
      grp_sat_q <= '1;
      all_sat_q <= 1'b1;
      ovf_q     <= 1'b0;
    end else if (beat) begin
      all_sat_q <= all_sat_q & clause;
      if (close) begin
        acc_q <= 1'b1;
        if (grp_q < GRP_W'(GROUPS)) begin
          for (int g = 0; g < GROUPS; g++) begin
            if (grp_q == GRP_W'(g)) grp_sat_q[g] <= acc_q & clause;
          end
          grp_q <= grp_q + 1'b1;
        end else begin
          // Groups past the last result bit only flag overflow.
          ovf_q <= 1'b1;
        end
      end else begin
        acc_q <= acc_q & clause;
      end
    end
  end

  assign bus.res_grp_sat = grp_sat_q;
  assign bus.res_all_sat = all_sat_q;
  assign bus.res_ovf     = ovf_q;

`ifdef CNF_UNSAT_TRACE_EN
  // ---------------------------------------------------------------------------
  // Unsat trace: failing-clause count and index of the first failing beat
  // ---------------------------------------------------------------------------
  logic [CNF_TRACE_W-1:0] beat_idx_q;
  logic [CNF_TRACE_W-1:0] unsat_cnt_q;
  logic [CNF_TRACE_W-1:0] first_fail_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      beat_idx_q   <= '0;
      unsat_cnt_q  <= '0;
      first_fail_q <= '1;
    end else if (beat) begin
      if (beat_idx_q != '1) beat_idx_q <= beat_idx_q + 1'b1;
      if (!clause) begin
        if (unsat_cnt_q != '1)  unsat_cnt_q  <= unsat_cnt_q + 1'b1;
        if (first_fail_q == '1) first_fail_q <= beat_idx_q;
      end
    end
  end

  assign bus.res_unsat_cnt  = unsat_cnt_q;
  assign bus.res_first_fail = first_fail_q;
`endif

endmodule
